// File: rtl/sram_ctrl_pkg.sv
// Shared types and default sizes for the 1RW+1R SRAM port controller.
package sram_ctrl_pkg;

    localparam int ADDR_WIDTH_DEF = 8;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int NUM_WMASKS_DEF = DATA_WIDTH_DEF / 8;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    typedef struct packed {
        logic                      we;
        logic [ADDR_WIDTH_DEF-1:0] addr;
        logic [DATA_WIDTH_DEF-1:0] wdata;
        logic [NUM_WMASKS_DEF-1:0] be;
    } a_req_t;

endpackage

// File: rtl/rsp_fifo.sv
// In-order response FIFO with valid/ready pop side and an occupancy count.
// The output word holds its last popped value while the FIFO is empty.
module rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pop_valid = (count_q != '0);
    assign pop       = pop_valid && pop_ready;
    assign pop_data  = pop_valid ? mem_q[rd_ptr_q] : last_q;
    assign count     = count_q;

    // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        last_d   = last_q;
        count_d  = count_q + CW'(push_valid) - CW'(pop);
        if (push_valid) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            last_d   = mem_q[rd_ptr_q];
        end
    end

    // NOTE: state registers use <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

    // NOTE: storage is not reset; count_q gates every read of it.
    always_ff @(posedge clk) begin
        if (push_valid) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/sram_port_ctrl.sv
// Initiator-side controller for the 1RW+1R OpenRAM macro: registered pin
// drive, credit-limited reads, write/read collision guard and a clear sweep.
module sram_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_WMASKS = NUM_WMASKS_DEF,
    parameter int RSP_DEPTH  = 2,
    parameter bit INIT_EN    = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_we,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_wdata,
    input  logic [NUM_WMASKS-1:0] a_req_be,
    output logic                  a_rsp_valid,
    input  logic                  a_rsp_ready,
    output logic [DATA_WIDTH-1:0] a_rsp_rdata,
    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    output logic                  b_rsp_valid,
    input  logic                  b_rsp_ready,
    output logic [DATA_WIDTH-1:0] b_rsp_rdata,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1,
    output logic                  init_done
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic                  init_done_q, init_done_d;

    logic                  csb0_q, csb0_d, web0_q, web0_d;
    logic [NUM_WMASKS-1:0] wmask0_q, wmask0_d;
    logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
    logic [DATA_WIDTH-1:0] din0_q, din0_d;
    logic                  csb1_q, csb1_d;
    logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;

    // p1: pins driven this cycle; p2: macro has sampled, dout valid this cycle.
    logic a_rd_p1_q, a_rd_p1_d, a_rd_p2_q, a_rd_p2_d;
    logic b_rd_p1_q, b_rd_p1_d, b_rd_p2_q, b_rd_p2_d;

    a_req_t        a_req;
    logic [CW-1:0] a_cnt, b_cnt;
    logic [CW:0]   a_used, b_used;
    logic          a_credit, b_credit, collision;
    logic          a_acc, a_rd_acc, b_acc;

    assign a_req = '{we: a_req_we, addr: a_req_addr, wdata: a_req_wdata, be: a_req_be};

    assign a_used   = {1'b0, a_cnt} + (CW+1)'(a_rd_p1_q) + (CW+1)'(a_rd_p2_q);
    assign b_used   = {1'b0, b_cnt} + (CW+1)'(b_rd_p1_q) + (CW+1)'(b_rd_p2_q);
    assign a_credit = (a_used < (CW+1)'(RSP_DEPTH));
    assign b_credit = (b_used < (CW+1)'(RSP_DEPTH));

    // Port B yields to a same-address write so the macro never sees both on one edge.
    assign collision   = a_req_valid && a_req.we && b_req_valid && (a_req.addr == b_req_addr);
    assign a_req_ready = init_done_q && (a_req.we || a_credit);
    assign b_req_ready = init_done_q && b_credit && !collision;

    assign a_acc    = a_req_valid && a_req_ready;
    assign a_rd_acc = a_acc && !a_req.we;
    assign b_acc    = b_req_valid && b_req_ready;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        unique case (state_q)
            INIT: begin
                init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
                if (init_cnt_q == LAST_ADDR) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            RUN: begin
                init_done_d = 1'b1;
            end
        endcase
    end

    always_comb begin
        csb0_d    = 1'b1;
        web0_d    = 1'b1;
        wmask0_d  = wmask0_q;
        addr0_d   = addr0_q;
        din0_d    = din0_q;
        csb1_d    = 1'b1;
        addr1_d   = addr1_q;
        a_rd_p1_d = a_rd_acc;
        a_rd_p2_d = a_rd_p1_q;
        b_rd_p1_d = b_acc;
        b_rd_p2_d = b_rd_p1_q;
        if (state_q == INIT) begin
            csb0_d   = 1'b0;
            web0_d   = 1'b0;
            wmask0_d = '1;
            addr0_d  = init_cnt_q;
            din0_d   = INIT_VALUE;
        end else if (a_acc) begin
            csb0_d   = 1'b0;
            web0_d   = !a_req.we;
            wmask0_d = a_req.be;
            addr0_d  = a_req.addr;
            din0_d   = a_req.wdata;
        end
        if (b_acc) begin
            csb1_d  = 1'b0;
            addr1_d = b_req_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= INIT_EN ? INIT : RUN;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            csb0_q      <= 1'b1;
            web0_q      <= 1'b1;
            wmask0_q    <= '0;
            addr0_q     <= '0;
            din0_q      <= '0;
            csb1_q      <= 1'b1;
            addr1_q     <= '0;
            a_rd_p1_q   <= 1'b0;
            a_rd_p2_q   <= 1'b0;
            b_rd_p1_q   <= 1'b0;
            b_rd_p2_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            csb0_q      <= csb0_d;
            web0_q      <= web0_d;
            wmask0_q    <= wmask0_d;
            addr0_q     <= addr0_d;
            din0_q      <= din0_d;
            csb1_q      <= csb1_d;
            addr1_q     <= addr1_d;
            a_rd_p1_q   <= a_rd_p1_d;
            a_rd_p2_q   <= a_rd_p2_d;
            b_rd_p1_q   <= b_rd_p1_d;
            b_rd_p2_q   <= b_rd_p2_d;
        end
    end

    rsp_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(DATA_WIDTH)) u_a_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_valid (a_rd_p2_q),
        .push_data  (sram_dout0),
        .pop_valid  (a_rsp_valid),
        .pop_ready  (a_rsp_ready),
        .pop_data   (a_rsp_rdata),
        .count      (a_cnt)
    );

    rsp_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(DATA_WIDTH)) u_b_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_valid (b_rd_p2_q),
        .push_data  (sram_dout1),
        .pop_valid  (b_rsp_valid),
        .pop_ready  (b_rsp_ready),
        .pop_data   (b_rsp_rdata),
        .count      (b_cnt)
    );

    assign sram_csb0   = csb0_q;
    assign sram_web0   = web0_q;
    assign sram_wmask0 = wmask0_q;
    assign sram_addr0  = addr0_q;
    assign sram_din0   = din0_q;
    assign sram_csb1   = csb1_q;
    assign sram_addr1  = addr1_q;
    assign init_done   = init_done_q;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl with a behavioural 1RW+1R macro and response scoreboards.
module tb_sram_port_ctrl;

    logic        clk, reset;
    logic        a_req_valid, a_req_ready, a_req_we;
    logic [7:0]  a_req_addr;
    logic [31:0] a_req_wdata;
    logic [3:0]  a_req_be;
    logic        a_rsp_valid, a_rsp_ready;
    logic [31:0] a_rsp_rdata;
    logic        b_req_valid, b_req_ready;
    logic [7:0]  b_req_addr;
    logic        b_rsp_valid, b_rsp_ready;
    logic [31:0] b_rsp_rdata;
    logic        sram_csb0, sram_web0, sram_csb1;
    logic [3:0]  sram_wmask0;
    logic [7:0]  sram_addr0, sram_addr1;
    logic [31:0] sram_din0, sram_dout0, sram_dout1;
    logic        init_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] data;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];

    sram_port_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .a_req_valid (a_req_valid),
        .a_req_ready (a_req_ready),
        .a_req_we    (a_req_we),
        .a_req_addr  (a_req_addr),
        .a_req_wdata (a_req_wdata),
        .a_req_be    (a_req_be),
        .a_rsp_valid (a_rsp_valid),
        .a_rsp_ready (a_rsp_ready),
        .a_rsp_rdata (a_rsp_rdata),
        .b_req_valid (b_req_valid),
        .b_req_ready (b_req_ready),
        .b_req_addr  (b_req_addr),
        .b_rsp_valid (b_rsp_valid),
        .b_rsp_ready (b_rsp_ready),
        .b_rsp_rdata (b_rsp_rdata),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_dout0  (sram_dout0),
        .sram_csb1   (sram_csb1),
        .sram_addr1  (sram_addr1),
        .sram_dout1  (sram_dout1),
        .init_done   (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Macro model: pins sampled on the edge, dout updated on the same edge.
    logic [31:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_A5A5;
        sram_dout0 = '0;
        sram_dout1 = '0;
    end

    always @(posedge clk) begin : sram_model
        logic [31:0] nw;
        if (!sram_csb0 && !sram_web0 && !sram_csb1) begin
            check("macro_same_addr_wr_rd", 64'(sram_addr0 == sram_addr1), 64'd0);
        end
        if (!sram_csb0) begin
            if (!sram_web0) begin
                nw = mem[sram_addr0];
                for (int l = 0; l < 4; l++) begin
                    if (sram_wmask0[l]) nw[8*l +: 8] = sram_din0[8*l +: 8];
                end
                mem[sram_addr0] <= nw;
            end else begin
                sram_dout0 <= mem[sram_addr0];
            end
        end
        if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
    end

    // Scoreboard monitor: compares each response handshake against the queue head.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            if (a_rsp_valid && a_rsp_ready) begin
                if (exp_a.size() == 0) begin
                    check("a_rsp_unexpected", 64'(a_rsp_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_a.pop_front();
                    check("a_rsp_rdata", 64'(a_rsp_rdata), 64'(e.data));
                    if (e.chk_lat) check("a_rsp_latency", 64'(cyc - e.acc_cyc), 64'd3);
                end
            end
            if (b_rsp_valid && b_rsp_ready) begin
                if (exp_b.size() == 0) begin
                    check("b_rsp_unexpected", 64'(b_rsp_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_b.pop_front();
                    check("b_rsp_rdata", 64'(b_rsp_rdata), 64'(e.data));
                    if (e.chk_lat) check("b_rsp_latency", 64'(cyc - e.acc_cyc), 64'd3);
                end
            end
        end
    end

    // Entered just after a rising edge; leaves just after the accepting edge.
    task automatic a_op(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp, input bit lat);
        int n = 0;
        a_req_valid = 1'b1;
        a_req_we    = we;
        a_req_addr  = addr;
        a_req_wdata = wdata;
        a_req_be    = be;
        @(negedge clk);
        while (!a_req_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("a_req_accept", 64'(a_req_ready), 64'd1);
        if (a_req_ready && !we) exp_a.push_back('{exp, cyc, lat});
        @(posedge clk);
        #1 a_req_valid = 1'b0;
    endtask

    task automatic b_op(input logic [7:0] addr, input logic [31:0] exp, input bit lat,
                        input bit expect_acc, input int max_wait);
        int n = 0;
        b_req_valid = 1'b1;
        b_req_addr  = addr;
        @(negedge clk);
        while (!b_req_ready && n < max_wait) begin
            n++;
            @(negedge clk);
        end
        check("b_req_accept", 64'(b_req_ready), 64'(expect_acc));
        if (b_req_ready) exp_b.push_back('{exp, cyc, lat});
        @(posedge clk);
        #1 b_req_valid = 1'b0;
    endtask

    // Checks n sweep cycles, starting with the first edge after reset release.
    task automatic sweep_check(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("sweep_pins", {sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0},
                  {1'b0, 1'b0, 4'hF, 8'(k), 32'h0});
            check("sweep_done_ready", {init_done, a_req_ready, b_req_ready},
                  (k == 255) ? 3'b111 : 3'b000);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 30) begin
            n++;
            @(negedge clk);
        end
        check("drain_a_empty", 64'(exp_a.size()), 64'd0);
        check("drain_b_empty", 64'(exp_b.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        reset       = 1'b1;
        a_req_valid = 1'b0;
        a_req_we    = 1'b1;
        a_req_addr  = '0;
        a_req_wdata = '0;
        a_req_be    = '0;
        a_rsp_ready = 1'b1;
        b_req_valid = 1'b0;
        b_req_addr  = '0;
        b_rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_pins", {sram_csb0, sram_web0, sram_csb1, sram_wmask0, sram_addr0, sram_addr1},
              {1'b1, 1'b1, 1'b1, 4'h0, 8'h00, 8'h00});
        check("rst_din0", 64'(sram_din0), 64'd0);
        check("rst_status", {init_done, a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid},
              5'b00000);
        check("rst_rdata", {a_rsp_rdata, b_rsp_rdata}, 64'd0);

        reset = 1'b0;
        sweep_check(256);
        @(posedge clk);
        #1;

        // Full-word write then read-back with latency check.
        a_op(1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
        a_op(1'b0, 8'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1);
        wait_drain();

        // Byte-lane 1 write, read through port B.
        a_op(1'b1, 8'h10, 32'h0000_AB00, 4'h2, 32'h0, 1'b0);
        b_op(8'h10, 32'hDEAD_ABEF, 1'b1, 1'b1, 20);
        wait_drain();

        // Same-cycle write on A and read on B to one address.
        a_req_valid = 1'b1;
        a_req_we    = 1'b1;
        a_req_addr  = 8'h20;
        a_req_wdata = 32'h1234_5678;
        a_req_be    = 4'hF;
        b_req_valid = 1'b1;
        b_req_addr  = 8'h20;
        @(negedge clk);
        check("collide_ready_ab", {a_req_ready, b_req_ready}, 2'b10);
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        @(negedge clk);
        check("retry_b_ready", 64'(b_req_ready), 64'd1);
        if (b_req_ready) exp_b.push_back('{32'h1234_5678, cyc, 1'b1});
        @(posedge clk);
        #1 b_req_valid = 1'b0;
        wait_drain();

        // Credit-limited burst on A with the consumer always ready.
        a_op(1'b0, 8'h10, 32'h0, 4'h0, 32'hDEAD_ABEF, 1'b1);
        a_op(1'b0, 8'h20, 32'h0, 4'h0, 32'h1234_5678, 1'b1);
        a_op(1'b0, 8'h30, 32'h0, 4'h0, 32'h0000_0000, 1'b1);
        wait_drain();

        // Backpressure on B: two credits, then ready stays low.
        b_rsp_ready = 1'b0;
        b_op(8'h30, 32'h0000_0000, 1'b0, 1'b1, 4);
        b_op(8'h10, 32'hDEAD_ABEF, 1'b0, 1'b1, 4);
        b_op(8'h20, 32'h0, 1'b0, 1'b0, 4);
        b_op(8'h40, 32'h0, 1'b0, 1'b0, 4);
        b_op(8'h50, 32'h0, 1'b0, 1'b0, 4);
        @(negedge clk);
        check("bp_hold", {b_req_ready, b_rsp_valid, b_rsp_rdata}, {1'b0, 1'b1, 32'h0});
        @(posedge clk);
        #1 b_rsp_ready = 1'b1;
        wait_drain();

        // Reset with two reads in flight.
        b_op(8'h10, 32'h0, 1'b0, 1'b1, 4);
        b_op(8'h20, 32'h0, 1'b0, 1'b1, 4);
        reset = 1'b1;
        exp_b.delete();
        #1;
        check("rst_async_csb", {sram_csb0, sram_csb1, sram_web0}, 3'b111);
        repeat (3) begin
            @(negedge clk);
            check("rst_rsp_valid", {a_rsp_valid, b_rsp_valid, init_done}, 3'b000);
        end
        reset = 1'b0;
        sweep_check(4);
        n = 0;
        while (!init_done && n < 300) begin
            n++;
            check("restart_rsp_valid", {a_rsp_valid, b_rsp_valid}, 2'b00);
            @(negedge clk);
        end
        check("restart_init_done", 64'(init_done), 64'd1);
        @(posedge clk);
        #1;
        a_op(1'b0, 8'h10, 32'h0, 4'h0, 32'h0000_0000, 1'b1);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
